// File: rtl/ss_mux_driver.sv
// Four-digit common-anode seven-segment scanner with dead-time blanking and PWM dimming.
// Optional build macro SS_LEADING_ZERO_BLANK_EN blanks a leading zero on digit 3.
module ss_mux_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic       Clk_100M,
   input  logic       Reset,
   input  logic [3:0] Digit3,
   input  logic [3:0] Digit2,
   input  logic [3:0] Digit1,
   input  logic [3:0] Digit0,
   input  logic [3:0] Dp,
   input  logic [7:0] Brightness,
   output logic [3:0] SegmentDrivers,
   output logic [7:0] SevenSegment
);

   localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYCLES);

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        pwm_q, pwm_d;
   logic [3:0]        lat_dig_q, lat_dig_d;
   logic              lat_dp_q, lat_dp_d;
   logic [7:0]        lat_br_q, lat_br_d;
   logic [3:0]        drv_q, drv_d;
   logic [7:0]        seg_q, seg_d;

   logic [3:0][3:0]   digits_w;
   logic [3:0]        sel_w;
   logic [6:0]        dec_w;
   logic              slot_last_w;
   logic              en_w;

   assign digits_w = {Digit3, Digit2, Digit1, Digit0};

   for (genvar gi = 0; gi < 4; gi++) begin : g_sel
      assign sel_w[gi] = (idx_q == 2'(gi));
   end

   // Active-low {g..a}; non-BCD codes stay dark.
   always_comb begin
      dec_w = 7'h7F;
      case (lat_dig_q)
         4'd0: dec_w = 7'h40;
         4'd1: dec_w = 7'h79;
         4'd2: dec_w = 7'h24;
         4'd3: dec_w = 7'h30;
         4'd4: dec_w = 7'h19;
         4'd5: dec_w = 7'h12;
         4'd6: dec_w = 7'h02;
         4'd7: dec_w = 7'h78;
         4'd8: dec_w = 7'h00;
         4'd9: dec_w = 7'h10;
         default: dec_w = 7'h7F;
      endcase
`ifdef SS_LEADING_ZERO_BLANK_EN
      if (idx_q == 2'd3 && lat_dig_q == 4'd0) begin
         dec_w = 7'h7F;
      end
`endif
   end

   assign slot_last_w = (slot_q == SLOT_LAST);
   assign en_w        = (slot_q >= DEAD_END) && (pwm_q < lat_br_q);

   always_comb begin
      slot_d    = slot_last_w ? '0 : slot_q + SLOT_W'(1);
      idx_d     = slot_last_w ? idx_q + 2'd1 : idx_q;
      pwm_d     = pwm_q + 8'd1;
      lat_dig_d = lat_dig_q;
      lat_dp_d  = lat_dp_q;
      lat_br_d  = lat_br_q;
      // Snapshot the slot's inputs once so mid-slot changes cannot tear the display.
      if (slot_q == '0) begin
         lat_dig_d = digits_w[idx_q];
         lat_dp_d  = Dp[idx_q];
         lat_br_d  = Brightness;
      end
      drv_d = 4'hF;
      seg_d = 8'hFF;
      if (en_w) begin
         drv_d = ~sel_w;
         seg_d = {~lat_dp_q, dec_w};
      end
   end

   always_ff @(posedge Clk_100M) begin
      if (Reset) begin
         slot_q    <= '0;
         idx_q     <= 2'd0;
         pwm_q     <= 8'd0;
         lat_dig_q <= 4'hF;
         lat_dp_q  <= 1'b0;
         lat_br_q  <= 8'd0;
         drv_q     <= 4'hF;
         seg_q     <= 8'hFF;
      end else begin
         slot_q    <= slot_d;
         idx_q     <= idx_d;
         pwm_q     <= pwm_d;
         lat_dig_q <= lat_dig_d;
         lat_dp_q  <= lat_dp_d;
         lat_br_q  <= lat_br_d;
         drv_q     <= drv_d;
         seg_q     <= seg_d;
      end
   end

   assign SegmentDrivers = drv_q;
   assign SevenSegment   = seg_q;

endmodule

// File: tb/tb_ss_mux_driver.sv
// Directed bench for ss_mux_driver: scan order, dead time, PWM, latching, reset and
// the leading-zero option; a second instance measures PWM duty over a long slot.
module tb_ss_mux_driver;

   localparam int RD = 8;
   localparam int DC = 2;

   logic       clk;
   logic       rst;
   logic       rst2;
   logic [3:0] d3, d2, d1, d0, dp;
   logic [7:0] br, br2;
   logic [3:0] drv, drv2;
   logic [7:0] seg, seg2;

   int n_cmp = 0;
   int n_err = 0;
   int g = 0;
   int base = 0;
   logic [7:0] exp_seg [4];
   int exp_br = 255;

   ss_mux_driver #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
      .Clk_100M(clk), .Reset(rst),
      .Digit3(d3), .Digit2(d2), .Digit1(d1), .Digit0(d0),
      .Dp(dp), .Brightness(br),
      .SegmentDrivers(drv), .SevenSegment(seg)
   );

   ss_mux_driver #(.REFRESH_DIV(1024), .DEAD_CYCLES(16)) dut_long (
      .Clk_100M(clk), .Reset(rst2),
      .Digit3(d3), .Digit2(d2), .Digit1(d1), .Digit0(d0),
      .Dp(dp), .Brightness(br2),
      .SegmentDrivers(drv2), .SevenSegment(seg2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, g, obs, req);
      end
   endtask

   // Output in a cycle reflects the counter state of the cycle before (p).
   task automatic expect_at(input int p, output logic [3:0] e_drv, output logic [7:0] e_seg);
      int s, i, pw;
      s  = p % RD;
      i  = (p / RD) % 4;
      pw = p % 256;
      e_drv = 4'hF;
      e_seg = 8'hFF;
      if (s >= DC && pw < exp_br) begin
         e_drv = ~(4'b0001 << i);
         e_seg = exp_seg[i];
      end
   endtask

   initial begin
      logic [3:0] e_drv;
      logic [7:0] e_seg;
      int cnt;

      rst = 1'b1; rst2 = 1'b1;
      d3 = 4'd2; d2 = 4'd3; d1 = 4'd5; d0 = 4'd9;
      dp = 4'b0000; br = 8'd255; br2 = 8'd128;
      exp_seg[0] = 8'h90; exp_seg[1] = 8'h92; exp_seg[2] = 8'hB0; exp_seg[3] = 8'hA4;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("reset_drv", {28'd0, drv}, 32'h0000000F);
         check("reset_seg", {24'd0, seg}, 32'h000000FF);
      end
      rst = 1'b0;

      for (int k = 1; k <= 254; k++) begin
         @(posedge clk); #1;
         g = k;
         if (g == 60)  exp_seg[1] = 8'hF8;
         if (g == 100) exp_seg[2] = 8'h7F;
`ifdef SS_LEADING_ZERO_BLANK_EN
         if (g == 110) exp_seg[3] = 8'hFF;
`else
         if (g == 110) exp_seg[3] = 8'hC0;
`endif
         if (g == 145) exp_br = 0;
         if (g == 185) exp_br = 255;

         if (g == 214) begin
            check("midrst_drv", {28'd0, drv}, 32'h0000000F);
            check("midrst_seg", {24'd0, seg}, 32'h000000FF);
            rst  = 1'b0;
            base = 214;
         end else begin
            expect_at(g - base - 1, e_drv, e_seg);
            check("drv", {28'd0, drv}, {28'd0, e_drv});
            check("seg", {24'd0, seg}, {24'd0, e_seg});
            check("one_enable", {31'd0, ($countones(~drv) <= 1)}, 32'd1);
         end

         if (g == 3)   check("first_on", {24'd0, drv, 4'd0} | {24'd0, seg}, 32'h000000F0 | 32'h00000090);
         if (g == 44)  d1 = 4'd7;
         if (g == 90)  begin d2 = 4'd12; dp = 4'b0100; end
         if (g == 100) d3 = 4'd0;
         if (g == 140) br = 8'd0;
         if (g == 180) br = 8'd255;
         if (g == 213) rst = 1'b1;
      end

      // 1024-cycle slot at half duty: active where p>=16 and p%256<128 -> 112+3*128.
      @(posedge clk); #1;
      rst2 = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 1024; k++) begin
         @(posedge clk); #1;
         if (drv2 != 4'hF) cnt++;
      end
      check("pwm_half_count", cnt, 32'd496);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
